// File: rtl/banked_sram_pkg.sv
// Shared types and geometry helpers for the banked SRAM controller.
package banked_sram_pkg;

  typedef enum logic {
    ST_INIT,
    ST_RUN
  } state_e;

  // Bits of the word address that select the bank (0 when there is a single bank).
  function automatic int bank_bits(input int num_banks);
    return (num_banks > 1) ? $clog2(num_banks) : 0;
  endfunction

  function automatic int row_bits(input int addr_w, input int num_banks);
    return addr_w - bank_bits(num_banks);
  endfunction

endpackage

// File: rtl/sram_bank.sv
// One SRAM bank: posedge write port and a registered read port sharing one address.
module sram_bank #(
  parameter int ROW_W  = 10,
  parameter int WORD_W = 8
) (
  input  logic              clk,
  input  logic              en,
  input  logic              we,
  input  logic [ROW_W-1:0]  addr,
  input  logic [WORD_W-1:0] wdata,
  output logic [WORD_W-1:0] rdata
);

  logic [WORD_W-1:0] mem [1<<ROW_W];

  // NOTE: the array has no reset branch; the controller's post-reset sweep clears it,
  // which keeps it mappable onto SRAM macros.
  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        mem[addr] <= wdata;
      end else begin
        rdata <= mem[addr];
      end
    end
  end

endmodule

// File: rtl/banked_sram_ctrl.sv
// Banked SRAM controller: INIT sweep then valid/ready request and read-response channels.
// Optional per-word even parity is enabled by defining PARITY_EN.
module banked_sram_ctrl
  import banked_sram_pkg::*;
#(
  parameter int ADDR_W    = 12,
  parameter int DATA_W    = 8,
  parameter int NUM_BANKS = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  input  logic              par_inject,
  output logic              init_done
);

  localparam int BANK_W = bank_bits(NUM_BANKS);
  localparam int ROW_W  = row_bits(ADDR_W, NUM_BANKS);
  localparam int RW     = (ROW_W > 0) ? ROW_W : 1;
  localparam int SEL_W  = (BANK_W > 0) ? BANK_W : 1;
  localparam int ROWS   = (1 << ADDR_W) / NUM_BANKS;
`ifdef PARITY_EN
  localparam int WORD_W = DATA_W + 1;
`else
  localparam int WORD_W = DATA_W;
`endif

  state_e            state, state_next;
  logic [RW-1:0]     cnt;
  logic [RW-1:0]     row;
  logic [SEL_W-1:0]  bank_sel;
  logic [SEL_W-1:0]  sel_q;
  logic              init_phase;
  logic              req_acc;
  logic              rd_acc;
  logic [WORD_W-1:0] req_word;
  logic [WORD_W-1:0] rsp_word;
  logic [WORD_W-1:0] bank_rdata [NUM_BANKS];

  // Address split; degenerate geometries get constant fields.
  generate
    if (NUM_BANKS == 1) begin : g_one_bank
      assign bank_sel = '0;
      assign row      = req_addr;
    end else if (ROW_W == 0) begin : g_one_row
      assign bank_sel = req_addr[BANK_W-1:0];
      assign row      = '0;
    end else begin : g_split
      assign bank_sel = req_addr[BANK_W-1:0];
      assign row      = req_addr[ADDR_W-1:BANK_W];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_INIT;
    end else begin
      state <= state_next;
    end
  end

  // NOTE: every output of this block gets a default first so no path leaves it unassigned,
  // which would otherwise infer a latch.
  always_comb begin
    state_next = state;
    init_done  = 1'b0;
    req_ready  = 1'b0;
    case (state)
      ST_INIT: begin
        if (cnt == RW'(ROWS - 1)) state_next = ST_RUN;
      end
      ST_RUN: begin
        init_done = 1'b1;
        req_ready = !rsp_valid | rsp_ready;
      end
      default: state_next = ST_INIT;
    endcase
  end

  assign init_phase = (state == ST_INIT);
  assign req_acc    = req_valid & req_ready & !rst;
  assign rd_acc     = req_acc & !req_we;

  // NOTE: registered state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (init_phase) begin
      cnt <= cnt + 1'b1;
    end
  end

`ifdef PARITY_EN
  assign req_word = {(^req_wdata) ^ par_inject, req_wdata};
`else
  logic unused_par;
  assign unused_par = par_inject;
  assign req_word   = req_wdata;
`endif

  // During INIT all banks take the zero word at the sweep row in parallel.
  for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
    logic              en;
    logic              we;
    logic [RW-1:0]     addr;
    logic [WORD_W-1:0] wdata;

    assign en    = !rst & (init_phase | (req_acc & (bank_sel == SEL_W'(b))));
    assign we    = init_phase | req_we;
    assign addr  = init_phase ? cnt : row;
    assign wdata = init_phase ? '0 : req_word;

    sram_bank #(
      .ROW_W (RW),
      .WORD_W(WORD_W)
    ) u_bank (
      .clk  (clk),
      .en   (en),
      .we   (we),
      .addr (addr),
      .wdata(wdata),
      .rdata(bank_rdata[b])
    );
  end

  // Bank read registers only move on an accepted read, so they hold data under back-pressure.
  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_valid <= 1'b0;
      sel_q     <= '0;
    end else if (rd_acc) begin
      rsp_valid <= 1'b1;
      sel_q     <= bank_sel;
    end else if (rsp_ready) begin
      rsp_valid <= 1'b0;
    end
  end

  assign rsp_word  = bank_rdata[sel_q];
  assign rsp_rdata = rsp_valid ? rsp_word[DATA_W-1:0] : '0;
`ifdef PARITY_EN
  assign rsp_err = rsp_valid & (^rsp_word);
`else
  assign rsp_err = 1'b0;
`endif

endmodule

// File: tb/tb_banked_sram_ctrl.sv
// Directed self-checking bench for banked_sram_ctrl (default geometry, 1024-row sweep).
module tb_banked_sram_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [11:0] req_addr;
  logic [7:0]  req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [7:0]  rsp_rdata;
  logic        rsp_err;
  logic        par_inject;
  logic        init_done;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  banked_sram_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .par_inject(par_inject),
    .init_done (init_done)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input logic [11:0] addr, input logic [7:0] data, input logic inj,
                          input string tag);
    req_valid = 1'b1; req_we = 1'b1; req_addr = addr; req_wdata = data; par_inject = inj;
    rsp_ready = 1'b1;
    #1 check({tag, "_ready"}, 32'(req_ready), 32'd1);
    tick();
    req_valid = 1'b0; req_we = 1'b0; par_inject = 1'b0;
    check({tag, "_norsp"}, 32'(rsp_valid), 32'd0);
  endtask

  task automatic do_read(input logic [11:0] addr, input logic [7:0] exp_data,
                         input logic exp_err, input string tag);
    req_valid = 1'b1; req_we = 1'b0; req_addr = addr; rsp_ready = 1'b1;
    #1 check({tag, "_ready"}, 32'(req_ready), 32'd1);
    tick();
    req_valid = 1'b0;
    check({tag, "_valid"}, 32'(rsp_valid), 32'd1);
    check({tag, "_data"},  32'(rsp_rdata), 32'(exp_data));
    check({tag, "_err"},   32'(rsp_err),   32'(exp_err));
    tick();
    check({tag, "_drop"}, 32'(rsp_valid), 32'd0);
  endtask

  initial begin
    int  early_done;
    int  early_rsp;
    int  waited;

    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0;
    rsp_ready = 1'b1; par_inject = 1'b0;
    tick();
    rst = 1'b0;

    // 1: reset values, then INIT lasts exactly 1024 cycles while ignoring a pending read.
    check("rst_init_done", 32'(init_done), 32'd0);
    check("rst_req_ready", 32'(req_ready), 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp_rdata", 32'(rsp_rdata), 32'd0);
    check("rst_rsp_err",   32'(rsp_err),   32'd0);
    req_valid = 1'b1; req_addr = 12'h003;
    early_done = 0; early_rsp = 0;
    for (int i = 1; i < 1024; i++) begin
      tick();
      if (init_done !== 1'b0 || req_ready !== 1'b0) early_done++;
      if (rsp_valid !== 1'b0) early_rsp++;
    end
    check("init_not_early", 32'(early_done), 32'd0);
    check("init_no_rsp",    32'(early_rsp),  32'd0);
    req_valid = 1'b0;
    tick();
    check("init_done_1024", 32'(init_done), 32'd1);
    check("run_req_ready",  32'(req_ready), 32'd1);

    // 2: contents cleared.
    do_read(12'h000, 8'h00, 1'b0, "clr_000");
    do_read(12'h001, 8'h00, 1'b0, "clr_001");
    do_read(12'h7FE, 8'h00, 1'b0, "clr_7fe");
    do_read(12'hFFF, 8'h00, 1'b0, "clr_fff");

    // 3: writes to banks 3 and 0, then read back.
    do_write(12'h003, 8'h5A, 1'b0, "wr_003");
    do_write(12'h004, 8'hA5, 1'b0, "wr_004");
    do_read(12'h003, 8'h5A, 1'b0, "rd_003");
    do_read(12'h004, 8'hA5, 1'b0, "rd_004");

    // 4: back-pressure holds the response, then back-to-back consume and accept.
    req_valid = 1'b1; req_we = 1'b0; req_addr = 12'h003; rsp_ready = 1'b0;
    tick();
    req_addr = 12'h004;
    for (int i = 0; i < 5; i++) begin
      check("bp_valid", 32'(rsp_valid), 32'd1);
      check("bp_data",  32'(rsp_rdata), 32'h5A);
      check("bp_ready", 32'(req_ready), 32'd0);
      tick();
    end
    rsp_ready = 1'b1;
    #1 check("bp_release_ready", 32'(req_ready), 32'd1);
    tick();
    req_valid = 1'b0;
    check("b2b_valid", 32'(rsp_valid), 32'd1);
    check("b2b_data",  32'(rsp_rdata), 32'hA5);
    tick();
    check("b2b_drop", 32'(rsp_valid), 32'd0);

    // 5: reset while a response is pending.
    req_valid = 1'b1; req_addr = 12'h003; rsp_ready = 1'b0;
    tick();
    req_valid = 1'b0;
    check("mid_pending", 32'(rsp_valid), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0; rsp_ready = 1'b1;
    check("mid_rsp_valid", 32'(rsp_valid), 32'd0);
    check("mid_init_done", 32'(init_done), 32'd0);
    check("mid_req_ready", 32'(req_ready), 32'd0);
    waited = 0;
    while (init_done !== 1'b1 && waited < 2000) begin
      tick();
      waited++;
    end
    check("mid_init_cycles", 32'(waited), 32'd1024);
    do_read(12'h003, 8'h00, 1'b0, "mid_rd_003");

`ifdef PARITY_EN
    // 6: injected parity error, then a clean rewrite.
    do_write(12'h010, 8'h5A, 1'b1, "par_inj_wr");
    do_read(12'h010, 8'h5A, 1'b1, "par_inj_rd");
    do_write(12'h010, 8'h5A, 1'b0, "par_ok_wr");
    do_read(12'h010, 8'h5A, 1'b0, "par_ok_rd");
`else
    // Without parity, par_inject has no effect on the read-back.
    do_write(12'h010, 8'h5A, 1'b1, "nopar_wr");
    do_read(12'h010, 8'h5A, 1'b0, "nopar_rd");
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
